// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: op codes, widths,
// FSM states, access-size decode and alignment helpers.
package mem_lsu_pkg;

  localparam int unsigned LSU_DW        = 32;
  localparam int unsigned LSU_AW        = 32;
  localparam int unsigned OP_W          = 8;
  localparam int unsigned REG_W         = 5;
  localparam int unsigned STALL_W       = 6;
  localparam int unsigned STALL_MEM_BIT = 4;
  localparam int unsigned LSU_ADEL_BIT  = 4;
  localparam int unsigned LSU_ADES_BIT  = 5;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } acc_size_e;

  typedef struct packed {
    logic      is_mem;
    logic      is_load;
    logic      sign;
    acc_size_e size;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [OP_W-1:0] op);
    op_dec_t d;
    d = '{1'b0, 1'b0, 1'b0, SZ_NONE};
    case (op)
      EXE_LB_OP:  d = '{1'b1, 1'b1, 1'b1, SZ_BYTE};
      EXE_LBU_OP: d = '{1'b1, 1'b1, 1'b0, SZ_BYTE};
      EXE_LH_OP:  d = '{1'b1, 1'b1, 1'b1, SZ_HALF};
      EXE_LHU_OP: d = '{1'b1, 1'b1, 1'b0, SZ_HALF};
      EXE_LW_OP:  d = '{1'b1, 1'b1, 1'b0, SZ_WORD};
      EXE_SB_OP:  d = '{1'b1, 1'b0, 1'b0, SZ_BYTE};
      EXE_SH_OP:  d = '{1'b1, 1'b0, 1'b0, SZ_HALF};
      EXE_SW_OP:  d = '{1'b1, 1'b0, 1'b0, SZ_WORD};
      default:    d = '{1'b0, 1'b0, 1'b0, SZ_NONE};
    endcase
    return d;
  endfunction

  function automatic logic is_aligned(input acc_size_e sz, input logic [1:0] ofs);
    case (sz)
      SZ_HALF: return ~ofs[0];
      SZ_WORD: return (ofs == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [1:0] align_ofs(input acc_size_e sz, input logic [1:0] ofs);
    case (sz)
      SZ_HALF: return {ofs[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return ofs;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Wishbone-classic data-bus bundle between the load/store unit (master) and memory (slave).
interface mem_lsu_if
  import mem_lsu_pkg::*;
#(
  parameter int unsigned AW = LSU_AW
) ();
  logic [AW-1:0]     wb_adr_o;
  logic [LSU_DW-1:0] wb_dat_o;
  logic [3:0]        wb_sel_o;
  logic              wb_we_o;
  logic              wb_stb_o;
  logic              wb_cyc_o;
  logic [LSU_DW-1:0] wb_dat_i;
  logic              wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/mem_lsu_lane_fmt.sv
// Big-endian byte-lane formatter: byte selects, store-data replication and
// load extraction with sign/zero extension.
module mem_lsu_lane_fmt
  import mem_lsu_pkg::*;
(
  input  acc_size_e   i_size,
  input  logic        i_sign,
  input  logic [1:0]  i_ofs,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_rd_data,
  output logic [3:0]  o_sel,
  output logic [31:0] o_st_data,
  output logic [31:0] o_ld_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin : p_fmt
    o_sel     = 4'b0000;
    o_st_data = ZERO_WORD;
    o_ld_data = ZERO_WORD;
    w_byte    = 8'h00;
    w_half    = 16'h0000;
    case (i_size)
      SZ_BYTE: begin
        o_sel     = 4'b1000 >> i_ofs;
        o_st_data = {4{i_st_data[7:0]}};
        case (i_ofs)
          2'b00:   w_byte = i_rd_data[31:24];
          2'b01:   w_byte = i_rd_data[23:16];
          2'b10:   w_byte = i_rd_data[15:8];
          default: w_byte = i_rd_data[7:0];
        endcase
        o_ld_data = {{24{i_sign & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_sel     = i_ofs[1] ? 4'b0011 : 4'b1100;
        o_st_data = {2{i_st_data[15:0]}};
        w_half    = i_ofs[1] ? i_rd_data[15:0] : i_rd_data[31:16];
        o_ld_data = {{16{i_sign & w_half[15]}}, w_half};
      end
      SZ_WORD: begin
        o_sel     = 4'b1111;
        o_st_data = i_st_data;
        o_ld_data = i_rd_data;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: one Wishbone-classic cycle per load/store with a
// stall request until completion. Optional macro LSU_UNALIGNED_EXC_EN raises
// address-error exceptions on misaligned accesses instead of masking the address.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned DW       = LSU_DW,
  parameter int unsigned AW       = LSU_AW,
  parameter int unsigned ADEL_BIT = LSU_ADEL_BIT,
  parameter int unsigned ADES_BIT = LSU_ADES_BIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    aluop_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [DW-1:0]      reg2_i,
  input  logic [REG_W-1:0]   waddr_i,
  input  logic               we_i,
  input  logic [DW-1:0]      wdata_i,
  input  logic [31:0]        excepttype_i,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  mem_lsu_if.master          bus,
  output logic [REG_W-1:0]   waddr_o,
  output logic               we_o,
  output logic [DW-1:0]      wdata_o,
  output logic [31:0]        excepttype_o,
  output logic               stallreq_o
);
  if (DW != 32) begin : g_bad_dw
    $error("mem_lsu: DW must be 32");
  end

  lsu_state_e r_state;
  logic [AW-1:0] r_adr;
  logic [31:0]   r_dat, r_hold;
  logic [3:0]    r_sel;
  logic          r_we, r_stb, r_cyc, r_load, r_sign, r_flushed;
  acc_size_e     r_size;
  logic [1:0]    r_ofs;

  op_dec_t    w_dec;
  logic [1:0] w_ofs;
  logic       w_issue, w_misaligned, w_start;
  acc_size_e  w_fmt_size;
  logic       w_fmt_sign;
  logic [1:0] w_fmt_ofs;
  logic [3:0] w_sel;
  logic [31:0] w_st_data, w_ld_data;
  logic       w_unused;

  assign w_dec    = decode_op(aluop_i);
  assign w_unused = ^{stall_i[5], stall_i[3:0]};

`ifdef LSU_UNALIGNED_EXC_EN
  assign w_ofs        = mem_addr_i[1:0];
  assign w_misaligned = w_dec.is_mem & ~is_aligned(w_dec.size, mem_addr_i[1:0]);
  assign w_issue      = w_dec.is_mem & ~w_misaligned;
`else
  assign w_ofs        = align_ofs(w_dec.size, mem_addr_i[1:0]);
  assign w_misaligned = 1'b0;
  assign w_issue      = w_dec.is_mem;
`endif

  assign w_start = (r_state == S_IDLE) & w_issue & ~flush_i & ~rst;

  // Issue uses the live op; the read-data path uses the op latched at issue.
  assign w_fmt_size = (r_state == S_IDLE) ? w_dec.size : r_size;
  assign w_fmt_sign = (r_state == S_IDLE) ? w_dec.sign : r_sign;
  assign w_fmt_ofs  = (r_state == S_IDLE) ? w_ofs      : r_ofs;

  mem_lsu_lane_fmt u_lane_fmt (
    .i_size    (w_fmt_size),
    .i_sign    (w_fmt_sign),
    .i_ofs     (w_fmt_ofs),
    .i_st_data (reg2_i),
    .i_rd_data (bus.wb_dat_i),
    .o_sel     (w_sel),
    .o_st_data (w_st_data),
    .o_ld_data (w_ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin : p_fsm
    if (rst) begin
      r_state   <= S_IDLE;
      r_adr     <= '0;
      r_dat     <= ZERO_WORD;
      r_hold    <= ZERO_WORD;
      r_sel     <= 4'b0000;
      r_we      <= 1'b0;
      r_stb     <= 1'b0;
      r_cyc     <= 1'b0;
      r_load    <= 1'b0;
      r_sign    <= 1'b0;
      r_flushed <= 1'b0;
      r_size    <= SZ_NONE;
      r_ofs     <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_cyc     <= 1'b1;
          r_stb     <= 1'b1;
          r_adr     <= AW'({mem_addr_i[31:2], 2'b00});
          r_sel     <= w_sel;
          r_we      <= ~w_dec.is_load;
          r_dat     <= w_st_data;
          r_load    <= w_dec.is_load;
          r_sign    <= w_dec.sign;
          r_size    <= w_dec.size;
          r_ofs     <= w_ofs;
          r_flushed <= 1'b0;
          r_state   <= S_BUSY;
        end
        S_BUSY: begin
          // A flush cannot abort the bus cycle; remember it and drop the result on ack.
          if (flush_i) r_flushed <= 1'b1;
          if (bus.wb_ack_i) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            if (r_flushed | flush_i) begin
              r_state <= S_IDLE;
            end else begin
              r_hold  <= w_ld_data;
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: if (flush_i || !stall_i[STALL_MEM_BIT]) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.wb_adr_o = r_adr;
  assign bus.wb_dat_o = r_dat;
  assign bus.wb_sel_o = r_sel;
  assign bus.wb_we_o  = r_we;
  assign bus.wb_stb_o = r_stb;
  assign bus.wb_cyc_o = r_cyc;

  always_comb begin : p_wb_out
    waddr_o    = waddr_i;
    we_o       = we_i;
    wdata_o    = wdata_i;
    stallreq_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        stallreq_o = w_start;
        if (w_dec.is_mem) we_o = 1'b0;
      end
      S_BUSY: begin
        stallreq_o = 1'b1;
        we_o       = 1'b0;
      end
      S_HOLD: begin
        we_o = r_load & we_i & ~flush_i;
        if (r_load) wdata_o = r_hold;
      end
      default: ;
    endcase
  end

  always_comb begin : p_exc
    excepttype_o = excepttype_i;
    if (w_misaligned) begin
      if (w_dec.is_load) excepttype_o[ADEL_BIT] = 1'b1;
      else               excepttype_o[ADES_BIT] = 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed table-driven bench for mem_lsu with a Wishbone slave that inserts
// a programmable number of wait states.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, excepttype_i;
  logic [4:0]  waddr_i;
  logic        we_i, flush_i;
  logic [5:0]  stall_i;
  logic [4:0]  waddr_o;
  logic        we_o, stallreq_o;
  logic [31:0] wdata_o, excepttype_o;

  logic [31:0] slv_rdata;
  logic [3:0]  slv_waits;
  logic [3:0]  r_wcnt;

  int n_checks = 0;
  int n_fail   = 0;

  mem_lsu_if #(.AW(32)) bus ();

  mem_lsu dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .waddr_i(waddr_i), .we_i(we_i), .wdata_i(wdata_i),
    .excepttype_i(excepttype_i), .stall_i(stall_i), .flush_i(flush_i),
    .bus(bus), .waddr_o(waddr_o), .we_o(we_o), .wdata_o(wdata_o),
    .excepttype_o(excepttype_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  assign bus.wb_ack_i = bus.wb_cyc_o & bus.wb_stb_o & (r_wcnt == slv_waits);
  assign bus.wb_dat_i = slv_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) r_wcnt <= 4'd0;
    else if (bus.wb_cyc_o & bus.wb_stb_o & ~bus.wb_ack_i) r_wcnt <= r_wcnt + 4'd1;
    else r_wcnt <= 4'd0;
  end

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr, reg2, rdata;
    logic [3:0]  waits;
    logic        exp_stb;
    logic [31:0] exp_adr;
    logic [3:0]  exp_sel;
    logic        exp_bwe;
    logic [31:0] exp_bdat;
    int          exp_stall;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_exc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, reg2, rdata,
                              input logic [3:0] waits, input logic stb, input logic [31:0] adr,
                              input logic [3:0] sel, input logic bwe, input logic [31:0] bdat,
                              input int stall, input logic we, input logic [31:0] wdata,
                              input logic [31:0] exc);
    vec_t v;
    v.op = op; v.addr = addr; v.reg2 = reg2; v.rdata = rdata; v.waits = waits;
    v.exp_stb = stb; v.exp_adr = adr; v.exp_sel = sel; v.exp_bwe = bwe; v.exp_bdat = bdat;
    v.exp_stall = stall; v.exp_we = we; v.exp_wdata = wdata; v.exp_exc = exc;
    return v;
  endfunction

  task automatic drive(input logic [7:0] op, input logic [31:0] addr, reg2, rdata,
                       input logic [3:0] waits);
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2; slv_rdata = rdata; slv_waits = waits;
    we_i = 1'b1; waddr_i = 5'd7; wdata_i = 32'h0BAD_0000; excepttype_i = 32'h0000_0100;
    flush_i = 1'b0;
  endtask

  task automatic idle_inputs();
    aluop_i = 8'h00; we_i = 1'b0; flush_i = 1'b0; stall_i = 6'd0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cnt;
    logic saw;
    logic [31:0] s_adr, s_dat;
    logic [3:0] s_sel;
    logic s_we;
    cnt = 0; saw = 1'b0; s_adr = '0; s_dat = '0; s_sel = '0; s_we = 1'b0;
    @(negedge clk);
    drive(v.op, v.addr, v.reg2, v.rdata, v.waits);
    stall_i = 6'd0;
    #1;
    while (stallreq_o && cnt < 64) begin
      if (bus.wb_cyc_o & bus.wb_stb_o) begin
        saw = 1'b1; s_adr = bus.wb_adr_o; s_dat = bus.wb_dat_o;
        s_sel = bus.wb_sel_o; s_we = bus.wb_we_o;
      end
      @(negedge clk); #1;
      cnt++;
    end
    chk($sformatf("v%0d_stall_cycles", idx), 32'(cnt), 32'(v.exp_stall));
    chk($sformatf("v%0d_bus_issued", idx), 32'(saw), 32'(v.exp_stb));
    if (v.exp_stb) begin
      chk($sformatf("v%0d_adr", idx), s_adr, v.exp_adr);
      chk($sformatf("v%0d_sel", idx), 32'(s_sel), 32'(v.exp_sel));
      chk($sformatf("v%0d_bus_we", idx), 32'(s_we), 32'(v.exp_bwe));
      if (v.exp_bwe) chk($sformatf("v%0d_bus_dat", idx), s_dat, v.exp_bdat);
    end
    chk($sformatf("v%0d_we_o", idx), 32'(we_o), 32'(v.exp_we));
    if (v.exp_we) chk($sformatf("v%0d_wdata_o", idx), wdata_o, v.exp_wdata);
    chk($sformatf("v%0d_exc", idx), excepttype_o, v.exp_exc);
    chk($sformatf("v%0d_waddr", idx), 32'(waddr_o), 32'd7);
    idle_inputs();
  endtask

  initial begin
    int cnt;
    vecs[0]  = mk(EXE_LW_OP,  32'h100, 32'h0, 32'h1234_5678, 4'd0, 1, 32'h100, 4'b1111, 0, 32'h0, 2, 1, 32'h1234_5678, 32'h100);
    vecs[1]  = mk(EXE_LB_OP,  32'h103, 32'h0, 32'h0000_00F0, 4'd0, 1, 32'h100, 4'b0001, 0, 32'h0, 2, 1, 32'hFFFF_FFF0, 32'h100);
    vecs[2]  = mk(EXE_LBU_OP, 32'h103, 32'h0, 32'h0000_00F0, 4'd0, 1, 32'h100, 4'b0001, 0, 32'h0, 2, 1, 32'h0000_00F0, 32'h100);
    vecs[3]  = mk(EXE_LH_OP,  32'h102, 32'h0, 32'h1234_8001, 4'd1, 1, 32'h100, 4'b0011, 0, 32'h0, 3, 1, 32'hFFFF_8001, 32'h100);
    vecs[4]  = mk(EXE_LHU_OP, 32'h100, 32'h0, 32'h8001_1234, 4'd0, 1, 32'h100, 4'b1100, 0, 32'h0, 2, 1, 32'h0000_8001, 32'h100);
    vecs[5]  = mk(EXE_LB_OP,  32'h101, 32'h0, 32'h11A2_3344, 4'd0, 1, 32'h100, 4'b0100, 0, 32'h0, 2, 1, 32'hFFFF_FFA2, 32'h100);
    vecs[6]  = mk(EXE_SH_OP,  32'h202, 32'h0000_ABCD, 32'h0, 4'd3, 1, 32'h200, 4'b0011, 1, 32'hABCD_ABCD, 5, 0, 32'h0, 32'h100);
    vecs[7]  = mk(EXE_SB_OP,  32'h200, 32'h1234_567E, 32'h0, 4'd0, 1, 32'h200, 4'b1000, 1, 32'h7E7E_7E7E, 2, 0, 32'h0, 32'h100);
    vecs[8]  = mk(EXE_SW_OP,  32'h204, 32'hCAFE_BABE, 32'h0, 4'd2, 1, 32'h204, 4'b1111, 1, 32'hCAFE_BABE, 4, 0, 32'h0, 32'h100);
    vecs[9]  = mk(8'h25,      32'h204, 32'h0, 32'h0, 4'd0, 0, 32'h0, 4'b0000, 0, 32'h0, 0, 1, 32'h0BAD_0000, 32'h100);
`ifdef LSU_UNALIGNED_EXC_EN
    vecs[10] = mk(EXE_LW_OP,  32'h101, 32'h0, 32'h0A0B_0C0D, 4'd0, 0, 32'h0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 32'h110);
    vecs[11] = mk(EXE_SH_OP,  32'h203, 32'h1111_BEEF, 32'h0, 4'd0, 0, 32'h0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 32'h120);
`else
    vecs[10] = mk(EXE_LW_OP,  32'h101, 32'h0, 32'h0A0B_0C0D, 4'd0, 1, 32'h100, 4'b1111, 0, 32'h0, 2, 1, 32'h0A0B_0C0D, 32'h100);
    vecs[11] = mk(EXE_SH_OP,  32'h203, 32'h1111_BEEF, 32'h0, 4'd0, 1, 32'h200, 4'b0011, 1, 32'hBEEF_BEEF, 2, 0, 32'h0, 32'h100);
`endif

    // Reset with a load presented: nothing may start.
    rst = 1'b1;
    drive(EXE_LW_OP, 32'h100, 32'h0, 32'h0, 4'd0);
    stall_i = 6'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(bus.wb_stb_o), 32'd0);
    chk("rst_sel", 32'(bus.wb_sel_o), 32'd0);
    chk("rst_adr", bus.wb_adr_o, 32'd0);
    chk("rst_stallreq", 32'(stallreq_o), 32'd0);
    chk("rst_we_o", 32'(we_o), 32'd0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Flush during BUSY: bus completes, result discarded, unit returns to IDLE.
    @(negedge clk);
    drive(EXE_LW_OP, 32'h300, 32'h0, 32'h0000_0055, 4'd2);
    @(negedge clk); #1;
    chk("fl_busy_cyc", 32'(bus.wb_cyc_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk); #1;
    flush_i = 1'b0; aluop_i = 8'h00; we_i = 1'b0; wdata_i = 32'h0000_0A0A;
    #1;
    chk("fl_not_aborted", 32'(bus.wb_cyc_o), 32'd1);
    cnt = 0;
    while (stallreq_o && cnt < 64) begin @(negedge clk); #1; cnt++; end
    chk("fl_ack_in_budget", 32'(cnt < 64), 32'd1);
    chk("fl_cyc_dropped", 32'(bus.wb_cyc_o), 32'd0);
    chk("fl_we_o", 32'(we_o), 32'd0);
    chk("fl_wdata_discarded", wdata_o, 32'h0000_0A0A);
    idle_inputs();
    run_vec(vecs[0], 20);

    // HOLD with MEM/WB stalled, then flushed while holding.
    @(negedge clk);
    drive(EXE_LHU_OP, 32'h102, 32'h0, 32'h0000_C3A5, 4'd0);
    stall_i = 6'b01_0000;
    #1;
    cnt = 0;
    while (stallreq_o && cnt < 64) begin @(negedge clk); #1; cnt++; end
    chk("hold_stall_cycles", 32'(cnt), 32'd2);
    chk("hold_we_o", 32'(we_o), 32'd1);
    chk("hold_wdata", wdata_o, 32'h0000_C3A5);
    wdata_i = 32'h0000_0077;
    @(negedge clk); #1;
    chk("hold_kept_we", 32'(we_o), 32'd1);
    chk("hold_kept_wdata", wdata_o, 32'h0000_C3A5);
    chk("hold_no_stallreq", 32'(stallreq_o), 32'd0);
    flush_i = 1'b1;
    #1;
    chk("hold_flush_we", 32'(we_o), 32'd0);
    @(negedge clk);
    flush_i = 1'b0; stall_i = 6'd0; aluop_i = 8'h00; we_i = 1'b1;
    #1;
    chk("hold_flush_idle_wdata", wdata_o, 32'h0000_0077);
    chk("hold_flush_idle_we", 32'(we_o), 32'd1);
    idle_inputs();

    // Asynchronous reset in the middle of a bus cycle.
    @(negedge clk);
    drive(EXE_LW_OP, 32'h400, 32'h0, 32'h5555_AAAA, 4'd5);
    @(negedge clk); #1;
    chk("ar_stb_before", 32'(bus.wb_stb_o), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("ar_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("ar_stb", 32'(bus.wb_stb_o), 32'd0);
    chk("ar_sel", 32'(bus.wb_sel_o), 32'd0);
    chk("ar_adr", bus.wb_adr_o, 32'd0);
    chk("ar_stallreq", 32'(stallreq_o), 32'd0);
    chk("ar_we_o", 32'(we_o), 32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    run_vec(vecs[4], 21);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Memory-stage load/store unit. Consumes the EX/MEM pipeline-register outputs: aluop, effective address, store data (reg2), writeback fields and excepttype. Runs one Wishbone-classic data-bus transaction per load/store, requesting a pipeline stall until the access completes. Presents formatted writeback data and updated exception flags to the MEM/WB register; non-memory ops pass straight through.

Parameters:
DW, 32, data bus width (fixed at 32; any other value is a generation error)
AW, 32, address bus width
ADEL_BIT, 4, excepttype bit set on load address error
ADES_BIT, 5, excepttype bit set on store address error

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
aluop_i  in  8  op code from EX/MEM (`AluOpBus)
mem_addr_i  in  32  effective address
reg2_i  in  32  store data
waddr_i  in  5  destination GPR
we_i  in  1  GPR write enable
wdata_i  in  32  ALU result for non-memory ops
excepttype_i  in  32  upstream exception vector
stall_i  in  6  pipeline stall vector; bit 4 = MEM/WB hold
flush_i  in  1  pipeline flush
wb_dat_i  in  32  bus read data
wb_ack_i  in  1  bus acknowledge
wb_adr_o  out  AW  bus address, word-aligned
wb_dat_o  out  32  bus write data
wb_sel_o  out  4  byte lanes
wb_we_o  out  1  bus write
wb_stb_o, wb_cyc_o  out  1 each  bus strobe/cycle
waddr_o  out  5  writeback address
we_o  out  1  writeback enable
wdata_o  out  32  writeback data
excepttype_o  out  32  excepttype_i OR address-error bits
stallreq_o  out  1  stall request to the control unit

Behaviour:
- Ops: LB, LBU, LH, LHU, LW, SB, SH, SW. All other aluop values are non-memory and pass waddr/we/wdata through combinationally.
- Big-endian lanes.
  - Byte at addr[1:0]=00 uses sel 1000, data bits [31:24]; 11 uses 0001, bits [7:0].
  - Half at addr[1]=0 uses sel 1100; addr[1]=1 uses 0011.
  - Word uses sel 1111.
  - Stores replicate the byte or half across all lanes.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Alignment: a half access needs addr[0]=0; a word access needs addr[1:0]=00.
- FSM states:
  - IDLE:
    - An aligned memory op with flush_i=0 asserts stallreq_o combinationally. At the next edge it registers cyc=stb=1, adr={addr[31:2],00}, sel, we and dat, then goes to BUSY.
    - A non-memory op stays in IDLE.
  - BUSY:
    - stallreq_o=1 and we_o=0.
    - When wb_ack_i=1 at a clock edge: capture formatted read data into the hold register, drop cyc/stb at that edge, go to HOLD.
  - HOLD:
    - stallreq_o=0. Loads output we_o=we_i and wdata_o=hold register; stores output we_o=0.
    - If stall_i[4]=0 at an edge, go to IDLE; otherwise stay in HOLD.
- Latency with a zero-wait slave: op seen in cycle 0 (stallreq high), stb high in cycle 1 with ack in cycle 1, result valid in cycle 2. Each bus wait state adds one cycle.
- Flush:
  - In IDLE, flush_i=1 starts no transaction.
  - In BUSY, the bus cycle is not aborted; on ack the unit goes to IDLE and discards the data, and we_o stays 0.
  - In HOLD, flush_i=1 forces we_o=0 and the unit goes to IDLE at the next edge.
- stallreq_o is never high in HOLD, so issue/complete cannot deadlock against stall_i.
- Reset (async, any state): state=IDLE; all bus outputs, hold register and registered outputs go to 0. This applies mid-transaction too: the bus is dropped immediately.

Optional Feature:
LSU_UNALIGNED_EXC_EN
- Defined:
  - A misaligned load sets excepttype_o[ADEL_BIT]; a misaligned store sets excepttype_o[ADES_BIT].
  - No bus cycle is issued and stallreq_o stays 0.
  - we_o is forced to 0 for that instruction.
- Undefined: low address bits are masked to natural alignment (half: addr[0]=0, word: addr[1:0]=00), the access proceeds, and excepttype_o=excepttype_i.

Decomposition:
- Shared defines.v: EXE_OP_* load/store codes, ADEL/ADES bit indices, FSM state encodings, `ZeroWord.
- One natural sub-module: lsu_lane_fmt, combinational. It handles sel generation, store-data replication, and load extract/extension.

Test Plan:
- LW addr 0x100, zero-wait slave returns 0x12345678 -> stallreq high 2 cycles; cycle 2: we_o=1, wdata_o=0x12345678, sel 1111.
- LB addr 0x103, slave data 0x000000F0 -> sel 0001, wdata_o=0xFFFFFFF0; same access as LBU -> wdata_o=0x000000F0.
- SH addr 0x202, reg2_i 0x0000ABCD, slave with 3 wait states -> wb_dat_o=0xABCDABCD, sel 0011, we=1; stallreq high 5 cycles; we_o=0.
- LW issued, flush_i pulsed during BUSY -> bus completes on ack, we_o stays 0, unit returns to IDLE; next LW proceeds normally.
- rst asserted while BUSY -> cyc/stb drop asynchronously, all outputs 0, state IDLE.
- With LSU_UNALIGNED_EXC_EN, LW addr 0x101 -> no stb, excepttype_o bit 4 set, we_o=0; without the macro, bus adr 0x100.
